// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_pkg
// Description : Shared constants for the AXI4-Lite register responder:
//               response codes, FSM state encodings and window geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write FSM encoding
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;

  // Read FSM encoding
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // 4 KB window of 32-bit words
  localparam int ADDR_WIN_BITS = 12;
  localparam int WORD_LSB      = 2;
  localparam int IDX_BITS      = ADDR_WIN_BITS - WORD_LSB;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_addr_decode
// Description : Combinational window hit test and word index extraction.
//               The byte offset addr[1:0] plays no part in the decode.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          NUM_REGS  = 16
) (
  input  logic [31:0]         addr,
  output logic                hit,
  output logic [IDX_BITS-1:0] index
);

  // Byte offset within a word is deliberately ignored
  logic unused_lsb;
  assign unused_lsb = ^addr[WORD_LSB-1:0];

  assign index = addr[ADDR_WIN_BITS-1:WORD_LSB];
  assign hit   = (addr[31:ADDR_WIN_BITS] == BASE_ADDR[31:ADDR_WIN_BITS]) &&
                 (32'(index) < NUM_REGS);

endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_slave_regs
// Description : AXI4-Lite responder exposing NUM_REGS 32-bit registers in a
//               4 KB window at BASE_ADDR. Independent write and read FSMs,
//               one outstanding transaction per direction.
//               Build option AXIL_SLV_DECERR_EN: out-of-window accesses
//               answer DECERR instead of OKAY.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] awaddr_in,
  input  logic [2:0]  awprot_in,
  input  logic        awvalid_in,
  output logic        awready_out,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  wstrb_in,
  input  logic        wvalid_in,
  output logic        wready_out,
  output logic [1:0]  bresp_out,
  output logic        bvalid_out,
  input  logic        bready_in,
  input  logic [31:0] araddr_in,
  input  logic [2:0]  arprot_in,
  input  logic        arvalid_in,
  output logic        arready_out,
  output logic [31:0] rdata_out,
  output logic [1:0]  rresp_out,
  output logic        rvalid_out,
  input  logic        rready_in
);

`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] MISS_RESP = RESP_DECERR;
`else
  localparam logic [1:0] MISS_RESP = RESP_OKAY;
`endif

  // Protection attributes are accepted but carry no meaning here
  logic unused_prot;
  assign unused_prot = ^{awprot_in, arprot_in};

  // ---------------------------------------------------------------- write path
  logic [0:0]          w_state;
  logic [0:0]          w_state_next;
  logic                aw_held;
  logic                w_held;
  logic [31:0]         aw_addr_q;
  logic [31:0]         w_data_q;
  logic [3:0]          w_strb_q;
  logic [1:0]          bresp_q;
  logic                aw_fire;
  logic                w_fire;
  logic                do_write;
  logic [31:0]         wr_addr;
  logic [31:0]         wr_data;
  logic [3:0]          wr_strb;
  logic                wr_hit;
  logic [IDX_BITS-1:0] wr_idx;

  assign aw_fire = awvalid_in && awready_out;
  assign w_fire  = wvalid_in && wready_out;

  // Whichever half arrives on the completing edge is taken straight from the bus
  assign wr_addr = aw_held ? aw_addr_q : awaddr_in;
  assign wr_data = w_held  ? w_data_q  : wdata_in;
  assign wr_strb = w_held  ? w_strb_q  : wstrb_in;

  assign do_write = (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);

  axi4_lite_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_wr_decode (
    .addr  (wr_addr),
    .hit   (wr_hit),
    .index (wr_idx)
  );

  // Write FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_next;
    end
  end

  // Write FSM next-state logic
  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (do_write)  w_state_next = W_RESP;
      W_RESP:  if (bready_in) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write FSM outputs; readies come only from registered state
  always_comb begin
    awready_out = (w_state == W_IDLE) && !aw_held;
    wready_out  = (w_state == W_IDLE) && !w_held;
    bvalid_out  = (w_state == W_RESP);
    bresp_out   = bresp_q;
  end

  // Capture AW and W independently, release both when the write commits
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else if (do_write) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= wr_hit ? RESP_OKAY : MISS_RESP;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr_in;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= wdata_in;
        w_strb_q <= wstrb_in;
      end
    end
  end

  // ------------------------------------------------------------ register bank
  logic [NUM_REGS-1:0][31:0] reg_words;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [IDX_BITS-1:0] IDX = IDX_BITS'(i);
    logic [31:0] word;
    logic        sel;

    assign sel          = do_write && wr_hit && (wr_idx == IDX);
    assign reg_words[i] = word;

    // Byte-lane masked update of one register
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        word <= RESET_VAL;
      end else if (sel) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) word[8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read path
  logic [0:0]          r_state;
  logic [0:0]          r_state_next;
  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic                ar_fire;
  logic                rd_hit;
  logic [IDX_BITS-1:0] rd_idx;
  logic [31:0]         rd_word;

  assign ar_fire = arvalid_in && arready_out;

  axi4_lite_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_rd_decode (
    .addr  (araddr_in),
    .hit   (rd_hit),
    .index (rd_idx)
  );

  // Read mux over the register bank
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_BITS'(i)) rd_word = reg_words[i];
    end
  end

  // Read FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_next;
    end
  end

  // Read FSM next-state logic
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid_in) r_state_next = R_DATA;
      R_DATA:  if (rready_in)  r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    arready_out = (r_state == R_IDLE);
    rvalid_out  = (r_state == R_DATA);
    rdata_out   = rdata_q;
    rresp_out   = rresp_q;
  end

  // Load read data on the AR handshake; a concurrent write is not yet visible
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_fire) begin
      rdata_q <= rd_hit ? rd_word : 32'h0;
      rresp_q <= rd_hit ? RESP_OKAY : MISS_RESP;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_slave_regs
// Description : Self-checking bench for axi4_lite_slave_regs with a word-array
//               reference model; directed scenarios followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_slave_regs;

`ifdef AXIL_SLV_DECERR_EN
  localparam logic [1:0] MISS_RESP = 2'b11;
`else
  localparam logic [1:0] MISS_RESP = 2'b00;
`endif

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_regs [16];

  always #5 aclk = ~aclk;

  axi4_lite_slave_regs dut (
    .aclk        (aclk),
    .areset      (areset),
    .awaddr_in   (awaddr),
    .awprot_in   (awprot),
    .awvalid_in  (awvalid),
    .awready_out (awready),
    .wdata_in    (wdata),
    .wstrb_in    (wstrb),
    .wvalid_in   (wvalid),
    .wready_out  (wready),
    .bresp_out   (bresp),
    .bvalid_out  (bvalid),
    .bready_in   (bready),
    .araddr_in   (araddr),
    .arprot_in   (arprot),
    .arvalid_in  (arvalid),
    .arready_out (arready),
    .rdata_out   (rdata),
    .rresp_out   (rresp),
    .rvalid_out  (rvalid),
    .rready_in   (rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit model_hit(input logic [31:0] addr);
    return (addr[31:12] == 20'h00002) && (int'(addr[11:2]) < 16);
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (model_hit(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_regs[int'(addr[11:2])][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return model_hit(addr) ? model_regs[int'(addr[11:2])] : 32'h0;
  endfunction

  // w_lead > 0: W issued that many cycles before AW; < 0: AW leads
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int b_hold);
    int aw_start, w_start, cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [1:0] exp_resp;
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_start);
      wvalid  = !w_done && (cyc >= w_start);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      step();
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      if (w_done && !aw_done) check("wready_held_low", {31'b0, wready}, 32'h0);
      if (aw_done && !w_done) check("awready_held_low", {31'b0, awready}, 32'h0);
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    check("aw_w_accepted", {30'b0, aw_done, w_done}, 32'h3);
    exp_resp = model_hit(addr) ? 2'b00 : MISS_RESP;
    model_write(addr, data, strb);
    check("bvalid_latency", {31'b0, bvalid}, 32'h1);
    check("bresp", {30'b0, bresp}, {30'b0, exp_resp});
    for (int i = 0; i < b_hold; i++) begin
      step();
      check("bvalid_stable", {31'b0, bvalid}, 32'h1);
      check("bresp_stable", {30'b0, bresp}, {30'b0, exp_resp});
      check("readies_low_in_resp", {30'b0, awready, wready}, 32'h0);
    end
    bready = 1;
    step();
    bready = 0;
    check("bvalid_cleared", {31'b0, bvalid}, 32'h0);
    check("readies_after_b", {30'b0, awready, wready}, 32'h3);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_hold);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = model_read(addr);
    exp_resp = model_hit(addr) ? 2'b00 : MISS_RESP;
    check("arready_idle", {31'b0, arready}, 32'h1);
    araddr = addr;
    arvalid = 1;
    step();
    arvalid = 0;
    check("rvalid_latency", {31'b0, rvalid}, 32'h1);
    check("rdata", rdata, exp_data);
    check("rresp", {30'b0, rresp}, {30'b0, exp_resp});
    for (int i = 0; i < r_hold; i++) begin
      step();
      check("rdata_stable", rdata, exp_data);
      check("arready_low_in_data", {31'b0, arready}, 32'h0);
    end
    rready = 1;
    step();
    rready = 0;
    check("rvalid_cleared", {31'b0, rvalid}, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int kind;
    kind = $urandom_range(0, 9);
    if (kind < 6)       return {20'h00002, 6'b0, 4'($urandom_range(0, 15)), 2'($urandom)};
    else if (kind < 8)  return 32'h2000 + 32'($urandom_range(16, 1023)) * 4;
    else                return 32'h3000 + 32'($urandom_range(0, 4095));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;

    // Reset state
    #2;
    check("reset_readies", {29'b0, awready, wready, arready}, 32'h7);
    check("reset_valids", {30'b0, bvalid, rvalid}, 32'h0);
    check("reset_resps", {28'b0, bresp, rresp}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    step(); step();
    areset = 0;
    step();

    // Same-cycle AW/W then read back
    axi_write(32'h2004, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_read(32'h2004, 0);
    check("deadbeef", rdata, 32'hDEADBEEF);

    // W leads AW by three cycles with partial strobes
    axi_write(32'h2008, 32'hAAAAAAAA, 4'hF, -2, 0);
    axi_write(32'h2008, 32'h11223344, 4'b0101, 3, 0);
    axi_read(32'h2008, 1);
    check("strobe_merge", rdata, 32'hAA22AA44);

    // Back-pressure on B, then zero-strobe no-op write
    axi_write(32'h200C, 32'h0BADF00D, 4'hF, 0, 5);
    axi_write(32'h200C, 32'hFFFFFFFF, 4'h0, 1, 0);
    axi_read(32'h200C, 0);

    // Misses: other window and index beyond the bank
    axi_read(32'h3000, 0);
    axi_read(32'h2040, 2);
    axi_write(32'h2040, 32'h12345678, 4'hF, 0, 1);
    for (int i = 0; i < 16; i++) axi_read(32'h2000 + 32'(i) * 4, 0);

    // Read and write of the same register on the same edge
    axi_write(32'h2000, 32'h1, 4'hF, 0, 0);
    awaddr = 32'h2000; wdata = 32'h2; wstrb = 4'hF; araddr = 32'h2000;
    awvalid = 1; wvalid = 1; arvalid = 1;
    check("simul_readies", {29'b0, awready, wready, arready}, 32'h7);
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("simul_rdata_old", rdata, model_read(32'h2000));
    check("simul_valids", {30'b0, bvalid, rvalid}, 32'h3);
    model_write(32'h2000, 32'h2, 4'hF);
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    axi_read(32'h2000, 0);
    check("simul_rdata_new", rdata, 32'h2);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 0)
        axi_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 6) - 3, $urandom_range(0, 3));
      else
        axi_read(rand_addr(), $urandom_range(0, 2));
    end

    // Asynchronous reset while both directions are waiting on the master
    awaddr = 32'h2010; wdata = 32'hCAFE0001; wstrb = 4'hF; araddr = 32'h2004;
    awvalid = 1; wvalid = 1; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("pre_reset_valids", {30'b0, bvalid, rvalid}, 32'h3);
    areset = 1;
    #1;
    check("async_reset_valids", {30'b0, bvalid, rvalid}, 32'h0);
    check("async_reset_readies", {29'b0, awready, wready, arready}, 32'h7);
    for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
    step();
    areset = 0;
    step();
    for (int i = 0; i < 16; i++) axi_read(32'h2000 + 32'(i) * 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
